// File: rtl/led_matrix_pkg.sv
// rtl/led_matrix_pkg.sv - shared constants and scan state encoding for the LED matrix blocks
//
// Purpose: PWM width/range, default matrix geometry and the row-scan FSM
//          state type, shared by led_scan_ctrl and led_row_loader.
// Ports:   none (package).
package led_matrix_pkg;

  localparam int PWM_W    = 8;
  localparam int PWM_MAX  = 255;
  localparam int DEF_ROWS = 8;
  localparam int DEF_COLS = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRELOAD   = 2'd1,
    ST_WAIT_SYNC = 2'd2,
    ST_DISPLAY   = 2'd3
  } scan_state_e;

endpackage

// File: rtl/led_row_loader.sv
// rtl/led_row_loader.sv - fetches one row of brightness values from the frame buffer
//
// Purpose: on start_i, issues COLS consecutive frame-buffer reads for row_i
//          and forwards each returned byte (1-cycle read latency) to the
//          caller's shadow buffer write port. done_o marks the last write.
// Ports:
//   clk, rst_i        clock, synchronous active-high reset
//   abort_i           cancels any fetch in progress, in-flight data dropped
//   start_i, row_i    begin fetching row row_i (restarts if already busy)
//   fb_rd_en_o        frame-buffer read strobe
//   fb_addr_o         read address {row, col}
//   fb_rd_data_i      read data, valid one cycle after the strobe
//   sh_we_o           shadow write enable
//   sh_col_o          shadow column being written
//   sh_data_o         shadow write data
//   done_o            high in the cycle the last column is written
module led_row_loader
  import led_matrix_pkg::*;
#(
  parameter int COLS  = DEF_COLS,
  parameter int ROW_W = 3,
  parameter int COL_W = 3
) (
  input  logic                   clk,
  input  logic                   rst_i,
  input  logic                   abort_i,
  input  logic                   start_i,
  input  logic [ROW_W-1:0]       row_i,
  output logic                   fb_rd_en_o,
  output logic [ROW_W+COL_W-1:0] fb_addr_o,
  input  logic [PWM_W-1:0]       fb_rd_data_i,
  output logic                   sh_we_o,
  output logic [COL_W-1:0]       sh_col_o,
  output logic [PWM_W-1:0]       sh_data_o,
  output logic                   done_o
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  logic             rd_en_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  // Read-latency pipeline: remembers which column the returning data belongs to.
  logic             pend_q;
  logic [COL_W-1:0] pend_col_q;

  always_ff @(posedge clk) begin
    if (rst_i || abort_i) begin
      rd_en_q    <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      pend_q     <= 1'b0;
      pend_col_q <= '0;
    end else begin
      pend_q     <= rd_en_q;
      pend_col_q <= col_q;
      if (start_i) begin
        rd_en_q <= 1'b1;
        row_q   <= row_i;
        col_q   <= '0;
      end else if (rd_en_q) begin
        if (col_q == LAST_COL) begin
          rd_en_q <= 1'b0;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  assign fb_rd_en_o = rd_en_q;
  assign fb_addr_o  = {row_q, col_q};
  assign sh_we_o    = pend_q;
  assign sh_col_o   = pend_col_q;
  assign sh_data_o  = fb_rd_data_i;
  assign done_o     = pend_q && (pend_col_q == LAST_COL);

endmodule

// File: rtl/led_scan_ctrl.sv
// rtl/led_scan_ctrl.sv - LED matrix row-scan scheduler with background row prefetch
//
// Purpose: displays one row at a time, swapping a prefetched shadow row into
//          the active buffer on PWM cycle boundaries, and drives PWM-compared
//          column enables with an anti-ghosting blank at the start of each cycle.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   en                scan enable; low returns to IDLE immediately
//   pwm_counter       free-running PWM count 0..255
//   pwm_cycle_end     one-cycle pulse coincident with pwm_counter == 0
//   fb_rd_en, fb_addr frame-buffer read strobe and {row, col} address
//   fb_rd_data        frame-buffer data, one cycle after the strobe
//   row_sel           one-hot active row (all zero = no row driven)
//   col_on            column drive, 1 = LED on
//   frame_done        pulse on the swap that wraps the last row back to row 0
//   busy              high whenever the FSM is not IDLE
module led_scan_ctrl
  import led_matrix_pkg::*;
#(
  parameter int ROWS       = DEF_ROWS,
  parameter int COLS       = DEF_COLS,
  parameter int ROW_W      = 3,
  parameter int COL_W      = 3,
  parameter int REPEAT     = 1,
  parameter int BLANK_CLKS = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [PWM_W-1:0]       pwm_counter,
  input  logic                   pwm_cycle_end,
  output logic                   fb_rd_en,
  output logic [ROW_W+COL_W-1:0] fb_addr,
  input  logic [PWM_W-1:0]       fb_rd_data,
  output logic [ROWS-1:0]        row_sel,
  output logic [COLS-1:0]        col_on,
  output logic                   frame_done,
  output logic                   busy
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [7:0]       REP_LAST = 8'(REPEAT - 1);
  localparam logic [PWM_W-1:0] BLANK    = PWM_W'(BLANK_CLKS);
  localparam logic [ROWS-1:0]  ROW0_SEL = ROWS'(1);

  scan_state_e      state_q;
  logic [ROW_W-1:0] row_q;
  logic [7:0]       rep_q;
  logic [PWM_W-1:0] active_q [COLS];
  logic [PWM_W-1:0] shadow_q [COLS];
  logic [ROWS-1:0]  row_sel_q;
  logic [COLS-1:0]  col_on_q;
  logic [COLS-1:0]  col_on_d;
  logic             frame_done_q;

  logic [ROW_W-1:0] row_nxt;
  logic [ROW_W-1:0] ld_row;
  logic             ld_start;
  logic             ld_done;
  logic             sh_we;
  logic [COL_W-1:0] sh_col;
  logic [PWM_W-1:0] sh_data;
  logic             swap;

  function automatic logic [ROW_W-1:0] wrap_inc(input logic [ROW_W-1:0] r);
    return (r == LAST_ROW) ? '0 : r + 1'b1;
  endfunction

  always_comb begin
    row_nxt  = wrap_inc(row_q);
    // rep_q never exceeds REP_LAST, so equality marks the last repeat.
    swap     = (state_q == ST_DISPLAY) && pwm_cycle_end && (rep_q == REP_LAST);
    ld_start = 1'b0;
    ld_row   = '0;
    if (en) begin
      case (state_q)
        ST_IDLE: begin
          ld_start = 1'b1;
          ld_row   = '0;
        end
        ST_WAIT_SYNC: begin
          if (pwm_cycle_end) begin
            ld_start = 1'b1;
            ld_row   = wrap_inc('0);
          end
        end
        ST_DISPLAY: begin
          // Prefetch the row that follows the one being swapped in.
          if (swap) begin
            ld_start = 1'b1;
            ld_row   = wrap_inc(row_nxt);
          end
        end
        default: ;
      endcase
    end
    col_on_d = '0;
    for (int c = 0; c < COLS; c++) begin
      col_on_d[c] = en && (state_q == ST_DISPLAY) &&
                    (active_q[c] > pwm_counter) && (pwm_counter >= BLANK);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      rep_q        <= '0;
      row_sel_q    <= '0;
      col_on_q     <= '0;
      frame_done_q <= 1'b0;
      for (int c = 0; c < COLS; c++) begin
        active_q[c] <= '0;
        shadow_q[c] <= '0;
      end
    end else begin
      col_on_q     <= col_on_d;
      frame_done_q <= 1'b0;
      if (sh_we && en) begin
        shadow_q[sh_col] <= sh_data;
      end
      if (!en) begin
        state_q   <= ST_IDLE;
        row_q     <= '0;
        rep_q     <= '0;
        row_sel_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: state_q <= ST_PRELOAD;
          ST_PRELOAD: begin
            if (ld_done) state_q <= ST_WAIT_SYNC;
          end
          ST_WAIT_SYNC: begin
            if (pwm_cycle_end) begin
              state_q   <= ST_DISPLAY;
              active_q  <= shadow_q;
              row_q     <= '0;
              row_sel_q <= ROW0_SEL;
              rep_q     <= '0;
            end
          end
          ST_DISPLAY: begin
            if (swap) begin
              active_q     <= shadow_q;
              row_q        <= row_nxt;
              row_sel_q    <= ROW0_SEL << row_nxt;
              rep_q        <= '0;
              frame_done_q <= (row_q == LAST_ROW);
            end else if (pwm_cycle_end) begin
              rep_q <= rep_q + 8'd1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  led_row_loader #(
    .COLS (COLS),
    .ROW_W(ROW_W),
    .COL_W(COL_W)
  ) u_loader (
    .clk         (clk),
    .rst_i       (rst),
    .abort_i     (!en),
    .start_i     (ld_start),
    .row_i       (ld_row),
    .fb_rd_en_o  (fb_rd_en),
    .fb_addr_o   (fb_addr),
    .fb_rd_data_i(fb_rd_data),
    .sh_we_o     (sh_we),
    .sh_col_o    (sh_col),
    .sh_data_o   (sh_data),
    .done_o      (ld_done)
  );

  assign row_sel    = row_sel_q;
  assign col_on     = col_on_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
